// File: rtl/pc_fetch_sequencer.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Owns the program counter and sequences instruction fetch over a req/ack
// handshake with instruction memory. Each instruction walks FETCH -> WAIT ->
// EXEC. The next PC is chosen on the cycle EXEC is left. Sources, in priority
// order, are jr > j > br_taken > pc+4. A redirect counts only when
// redirect_valid is high.
//
// Parameters
//   RESET_PC  PC loaded on reset
//   TRAP_PC   vector taken on a misaligned jr target (align check build only)
//   MAX_WAIT  WAIT cycles without ack before the sticky timeout flag sets
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   stall               hold pc/instr in EXEC, no new fetch
//   j, j_addr           pseudo-direct jump {pc+4[31:28], j_addr, 2'b00}
//   jr, jr_target       jump to register value
//   br_taken, br_offset branch to pc+4 + sign-extended word offset
//   redirect_valid      qualifies j / jr / br_taken
//   imem_req, imem_addr fetch request and address (= pc)
//   imem_ack, imem_rdata fetched word, honoured only in WAIT
//   pc, instr           PC and instruction held for decode
//   instr_valid         high while an instruction sits in EXEC
//   timeout             sticky: a fetch waited MAX_WAIT cycles or more
//   align_trap          (PC_ALIGN_CHECK_EN only) one-cycle pulse in the
//                       FETCH cycle after a misaligned next PC was trapped
//
// Build option
//   PC_ALIGN_CHECK_EN   defined: misaligned next PC loads TRAP_PC and pulses
//                       align_trap. Undefined: the low two bits are dropped.
// ----------------------------------------------------------------------------
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0080,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        j,
    input  logic [25:0] j_addr,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        br_taken,
    input  logic [15:0] br_offset,
    input  logic        redirect_valid,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        timeout
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic        align_trap
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    state_t      state;
    state_t      state_n;
    logic [3:0]  wait_cnt;
    logic        leave_exec;
    logic [31:0] pc_plus4;
    logic [31:0] j_target;
    logic [31:0] br_target;
    logic [31:0] sel_pc;
    logic [31:0] next_pc;
`ifdef PC_ALIGN_CHECK_EN
    logic        misaligned;
`endif

    assign imem_addr  = pc;
    assign leave_exec = (state == S_EXEC) && !stall;

    // Next-PC selection. Every add is 32-bit, so wrap-around is natural.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        pc_plus4  = pc + 32'd4;
        j_target  = {pc_plus4[31:28], j_addr, 2'b00};
        br_target = pc_plus4 + {{14{br_offset[15]}}, br_offset, 2'b00};
        sel_pc    = pc_plus4;
        if (redirect_valid) begin
            if (jr) begin
                sel_pc = jr_target;
            end else if (j) begin
                sel_pc = j_target;
            end else if (br_taken) begin
                sel_pc = br_target;
            end
        end
`ifdef PC_ALIGN_CHECK_EN
        // Only jr can produce non-zero low bits.
        misaligned = (sel_pc[1:0] != 2'b00);
        next_pc    = misaligned ? TRAP_PC : sel_pc;
`else
        next_pc    = sel_pc & ~32'h3;
`endif
    end

    always_comb begin
        state_n = state;
        case (state)
            S_FETCH: state_n = S_WAIT;
            S_WAIT:  if (imem_ack) state_n = S_EXEC;
            S_EXEC:  if (!stall) state_n = S_FETCH;
            default: state_n = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples pre-edge values regardless of statement order.
        if (rst) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            timeout     <= 1'b0;
            wait_cnt    <= 4'd0;
`ifdef PC_ALIGN_CHECK_EN
            align_trap  <= 1'b0;
`endif
        end else begin
            state <= state_n;
            // Registered request. It is high for every FETCH/WAIT cycle
            // except the first FETCH after reset.
            imem_req <= (state_n != S_EXEC);

            if (state == S_WAIT) begin
                if (imem_ack) begin
                    instr       <= imem_rdata;
                    instr_valid <= 1'b1;
                end else begin
                    // Saturate so a very long wait cannot wrap the counter.
                    if (wait_cnt != WAIT_LIMIT) begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                    if (wait_cnt >= WAIT_LIMIT - 4'd1) begin
                        timeout <= 1'b1;
                    end
                end
            end

            if (leave_exec) begin
                pc          <= next_pc;
                instr_valid <= 1'b0;
                wait_cnt    <= 4'd0;
            end

`ifdef PC_ALIGN_CHECK_EN
            align_trap <= leave_exec && misaligned;
`endif
        end
    end

endmodule
